// File: rtl/gpio_irq.sv
// gpio_irq: debounced GPIO edge-interrupt block.
//
// Every bit of gpio_in goes through a two-flop synchronizer. The synchronized
// value is filtered into `level`. Edges on `level` that are enabled by
// rise_ena or fall_ena set sticky `status` bits. `irq` is the registered OR of
// `status`.
//
// Build option (macro GPIO_IRQ_DEBOUNCE_EN):
//   defined   - `level` follows the synchronized input only after it has
//               disagreed with `level` for DEBOUNCE consecutive cycles.
//               Latency from a clean input step to `level` is 2 + DEBOUNCE.
//   undefined - no counters are built. `level` is the synchronized input
//               registered once more, giving a latency of 3. DEBOUNCE is not
//               used for filtering in this build.
//
// Ports:
//   fclk        in   1      clock; all logic runs on the rising edge
//   fclk_rst_n  in   1      synchronous, active-low reset
//   gpio_in     in   WIDTH  asynchronous pad inputs
//   rise_ena    in   WIDTH  per-bit rising-edge interrupt enable
//   fall_ena    in   WIDTH  per-bit falling-edge interrupt enable
//   clr         in   WIDTH  per-bit write-1-to-clear pulse for status
//   level       out  WIDTH  debounced input level
//   status      out  WIDTH  sticky per-bit edge-event flags
//   irq         out  1      high while any status bit is set (registered)
module gpio_irq #(
    parameter int WIDTH    = 8,
    parameter int DEBOUNCE = 5000
) (
    input  logic             fclk,
    input  logic             fclk_rst_n,
    input  logic [WIDTH-1:0] gpio_in,
    input  logic [WIDTH-1:0] rise_ena,
    input  logic [WIDTH-1:0] fall_ena,
    input  logic [WIDTH-1:0] clr,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] status,
    output logic             irq
);

    // A zero or negative count would make the counter compare value wrap.
    if (DEBOUNCE < 1) begin : g_bad_debounce
        $error("gpio_irq: DEBOUNCE must be at least 1");
    end

    logic [WIDTH-1:0] sync_q1;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] level_d;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    // The only place gpio_in is sampled.
    always_ff @(posedge fclk) begin
        if (!fclk_rst_n) begin
            sync_q1 <= '0;
            sync    <= '0;
        end else begin
            sync_q1 <= gpio_in;
            sync    <= sync_q1;
        end
    end

`ifdef GPIO_IRQ_DEBOUNCE_EN
    // One extra bit allows DEBOUNCE-1 to be represented for any DEBOUNCE.
    localparam int CW = $clog2(DEBOUNCE) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    logic [CW-1:0] cnt [WIDTH];

    // The counter runs only while sync disagrees with level. Any agreement
    // restarts it, so a glitch shorter than DEBOUNCE cycles is dropped. The
    // counter is cleared when it loads level, so it cannot wrap.
    always_ff @(posedge fclk) begin
        if (!fclk_rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
            level <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    level[i] <= sync[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end
`else
    always_ff @(posedge fclk) begin
        if (!fclk_rst_n) begin
            level <= '0;
        end else begin
            level <= sync;
        end
    end
`endif

    // Edge detect on the filtered level. The enables are applied at the
    // moment of the edge only, so changing them never affects status that
    // is already set.
    always_comb begin
        rise = level & ~level_d & rise_ena;
        fall = ~level & level_d & fall_ena;
    end

    // In the status update a new event overrides a clear in the same cycle.
    always_ff @(posedge fclk) begin
        if (!fclk_rst_n) begin
            level_d <= '0;
            status  <= '0;
            irq     <= 1'b0;
        end else begin
            level_d <= level;
            status  <= (status & ~clr) | rise | fall;
            irq     <= |status;
        end
    end

endmodule

// File: tb/tb_gpio_irq.sv
// Bench for gpio_irq with WIDTH=8 and DEBOUNCE=4. A behavioural model
// predicts {irq, status, level} for every cycle into exp_q. A compare process
// pops one entry at each falling edge and checks the DUT against it. Directed
// sequences add literal expectations at the key cycles. The bench works with
// either setting of GPIO_IRQ_DEBOUNCE_EN.
module tb_gpio_irq;

    localparam int W   = 8;
    localparam int DEB = 4;
`ifdef GPIO_IRQ_DEBOUNCE_EN
    localparam int LAT = 2 + DEB;
`else
    localparam int LAT = 3;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n    = 1'b0;
    logic [W-1:0] gpio_in  = '0;
    logic [W-1:0] rise_ena = '0;
    logic [W-1:0] fall_ena = '0;
    logic [W-1:0] clr      = '0;
    logic [W-1:0] level;
    logic [W-1:0] status;
    logic         irq;

    gpio_irq #(.WIDTH(W), .DEBOUNCE(DEB)) dut (
        .fclk       (clk),
        .fclk_rst_n (rst_n),
        .gpio_in    (gpio_in),
        .rise_ena   (rise_ena),
        .fall_ena   (fall_ena),
        .clr        (clr),
        .level      (level),
        .status     (status),
        .irq        (irq)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        else
            n_pass++;
    endtask

    // ---------------- behavioural model ----------------
    // The filter rule is written over a window of recent synchronized
    // samples. A bit flips when the last DEB samples all differ from the
    // current level.
    logic [2*W:0] exp_q[$];
    logic [W-1:0] hist[$];
    logic [W-1:0] m_s1, m_s2, m_level, m_level_d, m_status, m_rise, m_fall, m_nl;
    logic         m_irq;
    logic         m_diff;
    bit           m_valid = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_level = '0; m_level_d = '0;
            m_status = '0; m_irq = 1'b0;
            hist.delete();
            m_valid = 1'b1;
        end else begin
            m_rise = m_level & ~m_level_d & rise_ena;
            m_fall = ~m_level & m_level_d & fall_ena;
`ifdef GPIO_IRQ_DEBOUNCE_EN
            hist.push_back(m_s2);
            if (hist.size() > DEB) void'(hist.pop_front());
            m_nl = m_level;
            if (hist.size() == DEB) begin
                for (int i = 0; i < W; i++) begin
                    m_diff = 1'b1;
                    foreach (hist[k]) if (hist[k][i] == m_level[i]) m_diff = 1'b0;
                    if (m_diff) m_nl[i] = ~m_level[i];
                end
            end
`else
            m_nl = m_s2;
`endif
            m_irq     = |m_status;
            m_status  = (m_status & ~clr) | m_rise | m_fall;
            m_level_d = m_level;
            m_level   = m_nl;
            m_s2      = m_s1;
            m_s1      = gpio_in;
        end
        if (m_valid) exp_q.push_back({m_irq, m_status, m_level});
    end

    // ---------------- scoreboard compare ----------------
    logic [2*W:0] exp_v;
    always @(negedge clk) begin
        if (m_valid) begin
            if (exp_q.size() == 0) begin
                check("sb_queue_empty", 32'd0, 32'd1);
            end else begin
                exp_v = exp_q.pop_front();
                check("sb_level",  32'(level),  32'(exp_v[W-1:0]));
                check("sb_status", 32'(status), 32'(exp_v[2*W-1:W]));
                check("sb_irq",    32'(irq),    32'(exp_v[2*W]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clr(input logic [W-1:0] v);
        clr = v;
        tick(1);
        clr = '0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        tick(3);
        rst_n = 1'b1;
        check("reset_level",  32'(level),  32'h00);
        check("reset_status", 32'(status), 32'h00);
        check("reset_irq",    32'(irq),    32'h0);

        // Rising step on bit 0.
        rise_ena = 8'h01;
        gpio_in  = 8'h01;
        tick(LAT - 1);
        check("rise_level_early", 32'(level), 32'h00);
        tick(1);
        check("rise_level",       32'(level),  32'h01);
        check("rise_status_lag",  32'(status), 32'h00);
        tick(1);
        check("rise_status",      32'(status), 32'h01);
        check("rise_irq_lag",     32'(irq),    32'h0);
        tick(1);
        check("rise_irq",         32'(irq),    32'h1);
        rise_ena = 8'h00;
        tick(1);
        check("ena_off_keeps",    32'(status), 32'h01);

        // A fall event on bit 0 coincides with its clear, and the event wins.
        fall_ena = 8'h01;
        gpio_in  = 8'h00;
        tick(LAT);
        check("fall_level", 32'(level), 32'h00);
        pulse_clr(8'h01);
        check("set_beats_clr", 32'(status), 32'h01);
        pulse_clr(8'h01);
        check("clr_status",   32'(status), 32'h00);
        check("clr_irq_lag",  32'(irq),    32'h1);
        tick(1);
        check("clr_irq",      32'(irq),    32'h0);
        fall_ena = 8'h00;

`ifdef GPIO_IRQ_DEBOUNCE_EN
        // A 3-cycle glitch on bit 3 is rejected.
        rise_ena = 8'hFF;
        gpio_in  = 8'h08;
        tick(3);
        gpio_in  = 8'h00;
        tick(10);
        check("glitch_level",  32'(level),  32'h00);
        check("glitch_status", 32'(status), 32'h00);
        check("glitch_irq",    32'(irq),    32'h0);
        rise_ena = 8'h00;
`else
        // Without the filter, a 1-cycle pulse on bit 5 shows up on level.
        rise_ena = 8'h20;
        gpio_in  = 8'h20;
        tick(1);
        gpio_in  = 8'h00;
        tick(2);
        check("pulse_level_hi", 32'(level),  32'h20);
        tick(1);
        check("pulse_level_lo", 32'(level),  32'h00);
        check("pulse_status",   32'(status), 32'h20);
        tick(1);
        check("pulse_irq",      32'(irq),    32'h1);
        pulse_clr(8'h20);
        tick(1);
        check("pulse_cleared",  32'(status), 32'h00);
        rise_ena = 8'h00;
`endif

        // All bits fall together; only falling edges are enabled.
        fall_ena = 8'hFF;
        gpio_in  = 8'hFF;
        tick(LAT + 3);
        check("all_hi_level",  32'(level),  32'hFF);
        check("all_hi_status", 32'(status), 32'h00);
        gpio_in = 8'h00;
        tick(LAT);
        check("all_lo_level",  32'(level),  32'h00);
        tick(1);
        check("all_fall_status", 32'(status), 32'hFF);
        tick(1);
        check("all_fall_irq",  32'(irq), 32'h1);
        pulse_clr(8'hFF);
        tick(1);
        check("all_cleared",   32'(status), 32'h00);
        fall_ena = 8'h00;

        // Reset in the middle of a count discards the samples taken before it.
        rise_ena = 8'h01;
        gpio_in  = 8'h01;
        tick(4);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("midrst_level",  32'(level),  32'h00);
        check("midrst_status", 32'(status), 32'h00);
        check("midrst_irq",    32'(irq),    32'h0);
        tick(LAT - 1);
        check("postrst_level_early", 32'(level), 32'h00);
        tick(1);
        check("postrst_level",  32'(level),  32'h01);
        tick(1);
        check("postrst_status", 32'(status), 32'h01);
        tick(1);
        check("postrst_irq",    32'(irq),    32'h1);

        tick(3);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gpio_irq.md
GPIO_IRQ -- requirements
Module: gpio_irq

Interface
REQ-001 Parameter: WIDTH, 8, number of GPIO input bits handled.
REQ-002 Parameter: DEBOUNCE, 5000, stable-sample count before a level change is accepted (50 us at 100 MHz fclk).
REQ-003 Port: fclk  input  1  sole clock; all logic on rising edge.
REQ-004 Port: fclk_rst_n  input  1  synchronous, active-low reset.
REQ-005 Port: gpio_in  input  WIDTH  asynchronous GPIO pad inputs (gpio[7:0] read side).
REQ-006 Port: rise_ena  input  WIDTH  per-bit rising-edge interrupt enable, fclk domain.
REQ-007 Port: fall_ena  input  WIDTH  per-bit falling-edge interrupt enable, fclk domain.
REQ-008 Port: clr  input  WIDTH  per-bit write-1-to-clear pulse for status, one fclk cycle wide.
REQ-009 Port: level  output  WIDTH  debounced input level.
REQ-010 Port: status  output  WIDTH  sticky per-bit edge-event flags.
REQ-011 Port: irq  output  1  interrupt request, level-high while any status bit is set.

Function
REQ-012 gpio_in SHALL pass through a two-flop synchronizer per bit (sync); no other logic samples gpio_in.
REQ-013 Per bit, a counter of width $clog2(DEBOUNCE)+1 SHALL clear to 0 whenever sync == level.
REQ-014 While sync != level, the counter SHALL increment by 1 per cycle; in the cycle it equals DEBOUNCE-1 with sync still != level, level SHALL load sync and the counter SHALL clear to 0.
REQ-015 A mismatch lasting fewer than DEBOUNCE consecutive cycles SHALL leave level unchanged (glitch rejection); counter never wraps.
REQ-016 Latency gpio_in change to level change SHALL be 2 + DEBOUNCE fclk cycles for a clean step.
REQ-017 level_d SHALL register level each cycle; rise[i] = level[i] & ~level_d[i] & rise_ena[i]; fall[i] = ~level[i] & level_d[i] & fall_ena[i].
REQ-018 status[i] SHALL set on the cycle after rise[i] or fall[i] is asserted and hold until cleared.
REQ-019 clr[i] SHALL clear status[i] on the next edge; if set and clr coincide for the same bit, set SHALL win.
REQ-020 Enable changes SHALL affect only future edges; deasserting an enable SHALL NOT clear an existing status bit.
REQ-021 irq SHALL be a register equal to OR of status, i.e. one cycle after status changes.
REQ-022 Bits SHALL be fully independent; simultaneous events on multiple bits SHALL all be recorded.

Reset
REQ-023 While fclk_rst_n == 0 at a rising edge: sync, counters, level, level_d, status, irq SHALL all go to 0.
REQ-024 After reset, an input held high SHALL produce level = 1 after 2 + DEBOUNCE cycles and a rise event if rise_ena is set.
REQ-025 Reset asserted mid-debounce SHALL abandon the count; no level change or event results from pre-reset samples.

Configuration
REQ-026 Macro GPIO_IRQ_DEBOUNCE_EN: when defined, debounce counters per REQ-013..REQ-016 SHALL be built.
REQ-027 When GPIO_IRQ_DEBOUNCE_EN is undefined, no counters SHALL exist, level SHALL equal sync registered once (latency 3 cycles), and DEBOUNCE SHALL be ignored.

Verification
REQ-028 DEBOUNCE=4, rise_ena=0x01: gpio_in[0] 0->1 -> level[0]=1 after 6 cycles, status=0x01 one cycle later, irq=1 one cycle after that.
REQ-029 DEBOUNCE=4: gpio_in[3] high pulse of 3 synchronized cycles -> level, status, irq remain 0.
REQ-030 status=0x01, clr=0x01 pulse -> status=0x00 next cycle, irq=0 following cycle; with a fall event on bit 0 in the same cycle -> status stays 0x01.
REQ-031 fall_ena=0xFF, rise_ena=0x00, gpio_in 0xFF->0x00 after settling -> status=0xFF, no status on the preceding 0x00->0xFF rise.
REQ-032 fclk_rst_n low for 1 cycle during count at 2 of 4 -> all outputs 0; gpio_in still high -> level=1 after 6 further cycles.
REQ-033 Build without GPIO_IRQ_DEBOUNCE_EN: gpio_in[5] 1-cycle-synchronized pulse -> level[5] pulses, status[5] set when rise_ena[5]=1.
